mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported, variable-latency memory between the
//             instruction-fetch stage and the load/store stage. Data accesses
//             win by default; a starvation counter forces a fetch grant after
//             STARVE_LIMIT consecutive data grants taken while a fetch waited.
//             One access is outstanding at a time; every access walks
//             IDLE -> BUSY -> RESP, so the repeat interval is at least 3 cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       asynchronous active-high reset
//   if_req_i     in   1       fetch request, held until if_valid_o
//   if_addr_i    in   ADDR_W  fetch address
//   if_data_o    out  DATA_W  fetched instruction, valid with if_valid_o
//   if_valid_o   out  1       one-cycle fetch completion pulse
//   if_stall_o   out  1       if_req_i & ~if_valid_o
//   dm_req_i     in   1       data request, held until dm_valid_o
//   dm_we_i      in   1       1 = store, 0 = load
//   dm_addr_i    in   ADDR_W  data address
//   dm_wdata_i   in   DATA_W  store data
//   dm_rdata_o   out  DATA_W  load data, valid with dm_valid_o
//   dm_valid_o   out  1       one-cycle data completion pulse
//   dm_stall_o   out  1       dm_req_i & ~dm_valid_o
//   mem_req_o    out  1       memory request, held until mem_ack_i
//   mem_we_o     out  1       memory write enable
//   mem_addr_o   out  ADDR_W  memory address
//   mem_wdata_o  out  DATA_W  memory write data
//   mem_ack_i    in   1       memory completion (may coincide with mem_req_o rise)
//   mem_rdata_i  in   DATA_W  memory read data, valid with mem_ack_i
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_valid_o,
   output logic              if_stall_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_valid_o,
   output logic              dm_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            state,      state_nx;
   logic [CNT_W-1:0]  starve_cnt, starve_cnt_nx;
   logic              resp_dm,    resp_dm_nx;     // RESP belongs to the data side
   logic [ADDR_W-1:0] addr_q,     addr_nx;
   logic              we_q,       we_nx;
   logic [DATA_W-1:0] wdata_q,    wdata_nx;
   logic [DATA_W-1:0] if_data_q,  if_data_nx;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_nx;

   logic              dm_wins;

   // Data wins unless a fetch is waiting and has already been passed over
   // STARVE_LIMIT times in a row.
   assign dm_wins = dm_req_i && (!if_req_i || (starve_cnt < LIMIT));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         starve_cnt <= '0;
         resp_dm    <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_data_q  <= '0;
         dm_rdata_q <= '0;
      end else begin
         state      <= state_nx;
         starve_cnt <= starve_cnt_nx;
         resp_dm    <= resp_dm_nx;
         addr_q     <= addr_nx;
         we_q       <= we_nx;
         wdata_q    <= wdata_nx;
         if_data_q  <= if_data_nx;
         dm_rdata_q <= dm_rdata_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      starve_cnt_nx = starve_cnt;
      resp_dm_nx    = resp_dm;
      addr_nx       = addr_q;
      we_nx         = we_q;
      wdata_nx      = wdata_q;
      if_data_nx    = if_data_q;
      dm_rdata_nx   = dm_rdata_q;

      case (state)
         IDLE: begin
            if (dm_wins) begin
               state_nx = DM_BUSY;
               addr_nx  = dm_addr_i;
               we_nx    = dm_we_i;
               wdata_nx = dm_wdata_i;
               // With a fetch waiting this branch is only reachable while
               // starve_cnt < LIMIT, so the increment saturates at LIMIT.
               if (if_req_i) begin
                  starve_cnt_nx = starve_cnt + CNT_W'(1);
               end else begin
                  starve_cnt_nx = '0;
               end
            end else if (if_req_i) begin
               state_nx      = IF_BUSY;
               addr_nx       = if_addr_i;
               we_nx         = 1'b0;
               wdata_nx      = '0;
               starve_cnt_nx = '0;
            end else begin
               starve_cnt_nx = '0;
            end
         end

         IF_BUSY: begin
            if (mem_ack_i) begin
               if_data_nx = mem_rdata_i;
               resp_dm_nx = 1'b0;
               state_nx   = RESP;
            end
         end

         DM_BUSY: begin
            if (mem_ack_i) begin
               // A store completes without disturbing the last load result.
               if (!we_q) begin
                  dm_rdata_nx = mem_rdata_i;
               end
               resp_dm_nx = 1'b1;
               state_nx   = RESP;
            end
         end

         RESP: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Memory side: request is a pure function of state so an async reset
   // drops it immediately.
   assign mem_req_o   = (state == IF_BUSY) || (state == DM_BUSY);
   assign mem_we_o    = (state == DM_BUSY) && we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   // Pipeline side
   assign if_data_o   = if_data_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_valid_o  = (state == RESP) && !resp_dm;
   assign dm_valid_o  = (state == RESP) &&  resp_dm;

   // Stalls depend only on request and valid, never on mem_ack_i.
   assign if_stall_o  = if_req_i && !if_valid_o;
   assign dm_stall_o  = dm_req_i && !dm_valid_o;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Directed stimulus
//             pushes hand-computed expectations into scoreboard queues; a
//             monitor on the falling edge pops and compares whenever the DUT
//             completes a fetch, a data access, or a memory transaction.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_valid;
   logic        if_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_t;

   logic [31:0] if_q[$];
   logic [31:0] dm_q[$];
   mem_t        mem_q[$];

   // memory model: configurable latency plus an injectable stray ack
   int   lat;
   int   busy_cnt;
   logic stray_ack;

   mem_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_data_o  (if_data),
      .if_valid_o (if_valid),
      .if_stall_o (if_stall),
      .dm_req_i   (dm_req),
      .dm_we_i    (dm_we),
      .dm_addr_i  (dm_addr),
      .dm_wdata_i (dm_wdata),
      .dm_rdata_o (dm_rdata),
      .dm_valid_o (dm_valid),
      .dm_stall_o (dm_stall),
      .mem_req_o  (mem_req),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_ack_i  (mem_ack),
      .mem_rdata_i(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_ack   = (mem_req && (busy_cnt == lat)) || stray_ack;
   assign mem_rdata = (mem_addr == 32'h40)  ? 32'h00A00093 :
                      (mem_addr == 32'h100) ? 32'hDEADBEEF :
                      {~mem_addr[15:0], mem_addr[15:0]};

   always @(posedge clk) begin
      if (!mem_req || mem_ack) busy_cnt <= 0;
      else                     busy_cnt <= busy_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (if_valid) begin
         if (if_q.size() == 0) check("if_unexpected_valid", 32'(if_valid), 32'd0);
         else check("if_data", if_data, if_q.pop_front());
      end
      if (dm_valid) begin
         if (dm_q.size() == 0) check("dm_unexpected_valid", 32'(dm_valid), 32'd0);
         else check("dm_rdata", dm_rdata, dm_q.pop_front());
      end
      if (mem_req) begin
         if (mem_q.size() == 0) begin
            check("mem_unexpected_req", 32'(mem_req), 32'd0);
         end else begin
            check("mem_we",   32'(mem_we), 32'(mem_q[0].we));
            check("mem_addr", mem_addr,    mem_q[0].addr);
            if (mem_q[0].we) check("mem_wdata", mem_wdata, mem_q[0].wdata);
            if (mem_ack) void'(mem_q.pop_front());
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   // Issue a fetch and wait for its completion; exp_cyc counts falling
   // edges from issue to the valid pulse.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_data,
                           input int exp_cyc, input logic keep);
      int n;
      n       = 0;
      if_req  = 1'b1;
      if_addr = a;
      if_q.push_back(exp_data);
      do begin
         @(negedge clk);
         n++;
         if (!if_valid) check("if_stall_busy", 32'(if_stall), 32'd1);
      end while (!if_valid && n < 200);
      if (!if_valid) check("if_timeout", 32'(n), 32'(exp_cyc));
      else begin
         check("if_latency", 32'(n), 32'(exp_cyc));
         check("if_stall_at_valid", 32'(if_stall), 32'd0);
      end
      #1;
      if (!keep) if_req = 1'b0;
   endtask

   task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rdata, input int exp_cyc, input logic keep);
      int n;
      n        = 0;
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = wd;
      dm_q.push_back(exp_rdata);
      do begin
         @(negedge clk);
         n++;
         if (n == 1 && !dm_valid) check("dm_stall_busy", 32'(dm_stall), 32'd1);
      end while (!dm_valid && n < 200);
      if (!dm_valid) check("dm_timeout", 32'(n), 32'(exp_cyc));
      else begin
         check("dm_latency", 32'(n), 32'(exp_cyc));
         check("dm_stall_at_valid", 32'(dm_stall), 32'd0);
      end
      #1;
      if (!keep) begin
         dm_req = 1'b0;
         dm_we  = 1'b0;
      end
   endtask

   logic [31:0] st_addr [6] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214};
   logic [31:0] st_exp  [6] = '{32'hFDFF0200, 32'hFDFB0204, 32'hFDF70208,
                                32'hFDF3020C, 32'hFDEF0210, 32'hFDEB0214};
   int          st_cyc  [6] = '{3, 4, 4, 4, 8, 4};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = '0; dm_wdata = '0; lat = 1; stray_ack = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req",   32'(mem_req),  32'd0);
      check("rst_mem_we",    32'(mem_we),   32'd0);
      check("rst_mem_addr",  mem_addr,      32'd0);
      check("rst_mem_wdata", mem_wdata,     32'd0);
      check("rst_if_valid",  32'(if_valid), 32'd0);
      check("rst_dm_valid",  32'(dm_valid), 32'd0);
      check("rst_if_data",   if_data,       32'd0);
      check("rst_dm_rdata",  dm_rdata,      32'd0);
      #1 rst = 1'b0;

      // 1. lone fetch, latency 2 -> valid 4 cycles after issue
      idle(2);
      lat = 2;
      mem_q.push_back('{1'b0, 32'h40, 32'h0});
      do_fetch(32'h40, 32'h00A00093, 4, 1'b0);

      // 2. collision: load served first, fetch granted in the following IDLE
      idle(2);
      lat = 1;
      mem_q.push_back('{1'b0, 32'h100, 32'h0});
      mem_q.push_back('{1'b0, 32'h44,  32'h0});
      fork
         do_fetch(32'h44, 32'hFFBB0044, 7, 1'b0);
         dm_access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
      join

      // 3. starvation: four loads, forced fetch, then the last two loads
      idle(2);
      for (int i = 0; i < 4; i++) mem_q.push_back('{1'b0, st_addr[i], 32'h0});
      mem_q.push_back('{1'b0, 32'h80, 32'h0});
      mem_q.push_back('{1'b0, st_addr[4], 32'h0});
      mem_q.push_back('{1'b0, st_addr[5], 32'h0});
      fork
         do_fetch(32'h80, 32'hFF7F0080, 19, 1'b0);
         begin
            for (int i = 0; i < 6; i++)
               dm_access(1'b0, st_addr[i], 32'h0, st_exp[i], st_cyc[i], (i < 5));
         end
      join
      idle(1);
      check("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);

      // 4. store: write strobe and data held until ack, rdata keeps last load
      idle(2);
      lat = 3;
      mem_q.push_back('{1'b1, 32'h8, 32'h12345678});
      dm_access(1'b1, 32'h8, 32'h12345678, 32'hFDEB0214, 5, 1'b0);

      // 5. zero-latency memory, continuous fetches every 3 cycles
      idle(2);
      lat = 0;
      mem_q.push_back('{1'b0, 32'h300, 32'h0});
      mem_q.push_back('{1'b0, 32'h304, 32'h0});
      mem_q.push_back('{1'b0, 32'h308, 32'h0});
      do_fetch(32'h300, 32'hFCFF0300, 2, 1'b1);
      do_fetch(32'h304, 32'hFCFB0304, 3, 1'b1);
      do_fetch(32'h308, 32'hFCF70308, 3, 1'b0);

      // 6. reset while DM_BUSY, late ack ignored, then normal operation
      idle(2);
      lat = 5;
      mem_q.push_back('{1'b0, 32'h500, 32'h0});
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
      repeat (2) @(negedge clk);
      check("busy_mem_req", 32'(mem_req), 32'd1);
      #1 rst = 1'b1;
      #1 check("rst_async_mem_req", 32'(mem_req), 32'd0);
      dm_req = 1'b0;
      mem_q.delete();
      stray_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_no_dm_valid", 32'(dm_valid), 32'd0);
      end
      #1 rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("stray_ack_no_dm_valid", 32'(dm_valid), 32'd0);
         check("stray_ack_no_if_valid", 32'(if_valid), 32'd0);
      end
      #1 stray_ack = 1'b0;
      lat = 1;
      mem_q.push_back('{1'b0, 32'h104, 32'h0});
      dm_access(1'b0, 32'h104, 32'h0, 32'hFEFB0104, 3, 1'b0);

      idle(3);
      check("if_q_drained",  32'(if_q.size()),  32'd0);
      check("dm_q_drained",  32'(dm_q.size()),  32'd0);
      check("mem_q_drained", 32'(mem_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
